// File: rtl/spu_pkg.sv
// Shared widths, forwarding codes and scoreboard entry layout for the even-pipe issue logic.
package spu_pkg;
   localparam int unsigned DEPTH  = 7;
   localparam int unsigned REG_AW = 7;
   localparam int unsigned LAT_W  = 4;
   localparam int unsigned SEL_W  = 4;

   localparam logic [SEL_W-1:0] FWD_RF = 4'd0;
   localparam logic [SEL_W-1:0] FWD_WB = 4'(DEPTH + 1);

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] dst;
      logic [LAT_W-1:0]  lat;
   } sb_entry_t;

   // Latency 0 behaves as 1; anything past the last result stage resolves there.
   function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
      if (lat == '0)
         return LAT_W'(1);
      if (lat > LAT_W'(DEPTH))
         return LAT_W'(DEPTH);
      return lat;
   endfunction
endpackage

// File: rtl/even_sb_match.sv
// Finds the youngest valid scoreboard entry writing a given register and reports
// whether its result is already available at that stage.
module even_sb_match
   import spu_pkg::*;
(
   input  logic [REG_AW-1:0]      i_src,
   input  sb_entry_t [DEPTH+1:1]  i_sb,
   output logic                   o_match,
   output logic                   o_ready,
   output logic [SEL_W-1:0]       o_k
);

   // Scan oldest to youngest so the lowest matching stage is the last one written.
   always_comb begin
      o_match = 1'b0;
      o_ready = 1'b0;
      o_k     = FWD_RF;
      for (int unsigned k = DEPTH + 1; k >= 1; k--) begin
         if (i_sb[k].v && (i_sb[k].dst == i_src)) begin
            o_match = 1'b1;
            o_ready = (SEL_W'(k) == FWD_WB) || (k >= 32'(i_sb[k].lat));
            o_k     = SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/even_issue_ctrl.sv
// Even-pipe issue controller: in-flight result scoreboard, RAW stall and per-operand
// forwarding select (regfile, result stage 1..7, or WB).
module even_issue_ctrl #(
   parameter int unsigned DEPTH  = spu_pkg::DEPTH,
   parameter int unsigned REG_AW = spu_pkg::REG_AW,
   parameter int unsigned LAT_W  = spu_pkg::LAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [REG_AW-1:0] in_reg_dst,
   input  logic              in_reg_wr,
   input  logic [LAT_W-1:0]  in_latency,
   input  logic [REG_AW-1:0] in_ra,
   input  logic [REG_AW-1:0] in_rb,
   input  logic [REG_AW-1:0] in_rc,
   input  logic              in_use_ra,
   input  logic              in_use_rb,
   input  logic              in_use_rc,
   output logic              iss_fire,
   output logic              iss_reg_wr,
   output logic [3:0]        fwd_sel_ra,
   output logic [3:0]        fwd_sel_rb,
   output logic [3:0]        fwd_sel_rc,
   output logic [15:0]       stall_cnt,
   output logic              sb_busy
);
   import spu_pkg::*;

   sb_entry_t [DEPTH+1:1] r_sb;
   logic [15:0]           r_stall_cnt;

   logic             w_match_ra, w_match_rb, w_match_rc;
   logic             w_ready_ra, w_ready_rb, w_ready_rc;
   logic [SEL_W-1:0] w_k_ra, w_k_rb, w_k_rc;
   logic             w_haz_ra, w_haz_rb, w_haz_rc;

   even_sb_match u_match_ra (
      .i_src(in_ra), .i_sb(r_sb), .o_match(w_match_ra), .o_ready(w_ready_ra), .o_k(w_k_ra)
   );
   even_sb_match u_match_rb (
      .i_src(in_rb), .i_sb(r_sb), .o_match(w_match_rb), .o_ready(w_ready_rb), .o_k(w_k_rb)
   );
   even_sb_match u_match_rc (
      .i_src(in_rc), .i_sb(r_sb), .o_match(w_match_rc), .o_ready(w_ready_rc), .o_k(w_k_rc)
   );

   assign w_haz_ra = in_use_ra && w_match_ra && !w_ready_ra;
   assign w_haz_rb = in_use_rb && w_match_rb && !w_ready_rb;
   assign w_haz_rc = in_use_rc && w_match_rc && !w_ready_rc;

   assign in_ready   = !rst && !(w_haz_ra || w_haz_rb || w_haz_rc);
   assign iss_fire   = in_valid && in_ready;
   assign iss_reg_wr = in_reg_wr && iss_fire;

   assign fwd_sel_ra = (in_use_ra && w_match_ra && w_ready_ra) ? w_k_ra : FWD_RF;
   assign fwd_sel_rb = (in_use_rb && w_match_rb && w_ready_rb) ? w_k_rb : FWD_RF;
   assign fwd_sel_rc = (in_use_rc && w_match_rc && w_ready_rc) ? w_k_rc : FWD_RF;

   assign stall_cnt = r_stall_cnt;

   always_comb begin
      sb_busy = 1'b0;
      for (int unsigned k = 1; k <= DEPTH + 1; k++)
         sb_busy = sb_busy | r_sb[k].v;
   end

   // Stage 1 is loaded every cycle; a non-firing cycle enters as an invalid bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sb        <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_sb[1] <= '{v: iss_reg_wr, dst: in_reg_dst, lat: clamp_lat(in_latency)};
         for (int unsigned k = 2; k <= DEPTH + 1; k++)
            r_sb[k] <= r_sb[k-1];
         if (in_valid && !in_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_even_issue_ctrl.sv
// Scoreboard bench for even_issue_ctrl: directed instruction sequences, expected forwarding
// pushed at presentation, checked by a monitor on every issue.
module tb_even_issue_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [6:0] in_reg_dst;
   logic       in_reg_wr;
   logic [3:0] in_latency;
   logic [6:0] in_ra, in_rb, in_rc;
   logic       in_use_ra, in_use_rb, in_use_rc;
   logic       iss_fire, iss_reg_wr;
   logic [3:0] fwd_sel_ra, fwd_sel_rb, fwd_sel_rc;
   logic [15:0] stall_cnt;
   logic       sb_busy;

   always #5 clk = ~clk;

   even_issue_ctrl #(.DEPTH(7), .REG_AW(7), .LAT_W(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg_dst(in_reg_dst), .in_reg_wr(in_reg_wr), .in_latency(in_latency),
      .in_ra(in_ra), .in_rb(in_rb), .in_rc(in_rc),
      .in_use_ra(in_use_ra), .in_use_rb(in_use_rb), .in_use_rc(in_use_rc),
      .iss_fire(iss_fire), .iss_reg_wr(iss_reg_wr),
      .fwd_sel_ra(fwd_sel_ra), .fwd_sel_rb(fwd_sel_rb), .fwd_sel_rc(fwd_sel_rc),
      .stall_cnt(stall_cnt), .sb_busy(sb_busy)
   );

   typedef struct {
      string      name;
      logic [3:0] ra, rb, rc;
      logic       wr;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Monitor: every issue must correspond to the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (iss_fire === 1'b1) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_fire: got fire expected none");
            end else begin
               e = q.pop_front();
               check({e.name, "_fwd_ra"}, 32'(fwd_sel_ra), 32'(e.ra));
               check({e.name, "_fwd_rb"}, 32'(fwd_sel_rb), 32'(e.rb));
               check({e.name, "_fwd_rc"}, 32'(fwd_sel_rc), 32'(e.rc));
               check({e.name, "_reg_wr"}, 32'(iss_reg_wr), 32'(e.wr));
            end
         end
      end
   end

   task automatic present(input int dst, input int wr, input int lat,
                          input int ra, input int ua, input int rb, input int ub,
                          input int rc, input int uc);
      in_reg_dst = 7'(dst);
      in_reg_wr  = 1'(wr);
      in_latency = 4'(lat);
      in_ra      = 7'(ra);
      in_use_ra  = 1'(ua);
      in_rb      = 7'(rb);
      in_use_rb  = 1'(ub);
      in_rc      = 7'(rc);
      in_use_rc  = 1'(uc);
      in_valid   = 1'b1;
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that accepted the instruction.
   task automatic issue(input string name, input int dst, input int wr, input int lat,
                        input int ra, input int ua, input int rb, input int ub,
                        input int rc, input int uc,
                        input int era, input int erb, input int erc, input int ewait);
      exp_t e;
      int   waits;
      present(dst, wr, lat, ra, ua, rb, ub, rc, uc);
      e.name = name;
      e.ra   = 4'(era);
      e.rb   = 4'(erb);
      e.rc   = 4'(erc);
      e.wr   = 1'(wr);
      q.push_back(e);
      waits = 0;
      forever begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         waits++;
         if (waits > 20) break;
      end
      check({name, "_wait"}, 32'(waits), 32'(ewait));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1;
      present(30, 1, 1, 1, 1, 2, 1, 3, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_in_ready",  32'(in_ready),  0);
      check("reset_iss_fire",  32'(iss_fire),  0);
      check("reset_sb_busy",   32'(sb_busy),   0);
      check("reset_stall_cnt", 32'(stall_cnt), 0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst      = 1'b0;

      // independent stream
      issue("ind_a", 3, 1, 2, 1, 1, 2, 1, 0, 0, 0, 0, 0, 0);
      issue("ind_b", 4, 1, 2, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0);
      check("ind_stall_cnt", 32'(stall_cnt), 0);
      idle(9);

      // RAW on a latency-2 producer
      issue("raw_p", 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("raw_c", 7, 1, 1, 3, 1, 0, 0, 0, 0, 2, 0, 0, 1);
      check("raw_stall_cnt", 32'(stall_cnt), 1);
      idle(9);

      // youngest producer governs
      issue("yw_p2", 3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("yw_p6", 3, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("yw_c",  8, 1, 1, 3, 1, 0, 0, 0, 0, 6, 0, 0, 5);
      check("yw_stall_cnt", 32'(stall_cnt), 6);
      idle(9);

      // write-back forwarding and drain
      issue("wb_p", 9, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("wb_sb_busy", 32'(sb_busy), 1);
      idle(7);
      issue("wb_c", 10, 0, 1, 9, 1, 0, 0, 0, 0, 8, 0, 0, 0);
      idle(9);
      issue("dr_p", 9, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(8);
      check("drain_sb_busy", 32'(sb_busy), 0);
      issue("dr_c", 10, 0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(9);

      // bubbles, unused sources, self-reference, rc forwarding
      issue("bub_p", 3, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("bub_c", 11, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("unu_p", 3, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("unu_c", 12, 1, 1, 10, 1, 3, 0, 0, 0, 0, 0, 0, 0);
      issue("self",  13, 1, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("rc_p",  20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue("rc_c",  21, 1, 1, 0, 0, 0, 0, 20, 1, 0, 0, 1, 0);
      check("misc_stall_cnt", 32'(stall_cnt), 6);
      idle(9);

      // reset while a reader is stalled on a latency-7 producer
      issue("rs_p", 12, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      present(14, 1, 1, 12, 1, 0, 0, 0, 0);
      @(negedge clk);
      check("rs_stall_rdy0", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rs_stall_rdy1", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      check("rs_pre_stall_cnt", 32'(stall_cnt), 8);
      rst = 1'b1;
      @(negedge clk);
      check("rs_iss_fire", 32'(iss_fire),  0);
      check("rs_sb_busy",  32'(sb_busy),   0);
      check("rs_stall_cnt", 32'(stall_cnt), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      issue("rs_c", 14, 1, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("rs_post_stall_cnt", 32'(stall_cnt), 0);

      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      check("queue_empty", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
